// File: rtl/nn_layer_engine.sv
// Fully-connected multi-layer inference engine: one MAC per cycle, ping-pong activations.
// Optional macro NN_SATURATE_EN saturates requantised sums instead of wrapping them.
module nn_layer_engine #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int NEURONS   = 4,
    parameter int LAYERS    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [15:0]       cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        act_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);
    localparam int ACC_W  = 2*DATA_W + $clog2(NEURONS) + 1;
    localparam int WDEPTH = LAYERS*NEURONS*NEURONS;
    localparam int BDEPTH = LAYERS*NEURONS;
    localparam int WAW    = $clog2(WDEPTH);
    localparam int BAW    = $clog2(BDEPTH);
    localparam int NW     = $clog2(NEURONS);
    localparam int LW     = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(NEURONS-1);
    localparam logic [LW-1:0] L_LAST = LW'(LAYERS-1);
    localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(1 << FRAC_BITS);
    localparam logic signed [DATA_W-1:0] NEG_ONE = -ONE;
    localparam logic signed [DATA_W-1:0] HALF    = DATA_W'(1 << (FRAC_BITS-1));

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INIT, S_MAC, S_ACT, S_OUT} state_t;

    state_t                   r_state;
    logic [1:0]               r_mode;
    logic                     r_pp;
    logic [LW-1:0]            r_layer;
    logic [NW-1:0]            r_neuron;
    logic [NW-1:0]            r_idx;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_w   [WDEPTH];
    logic signed [DATA_W-1:0] r_b   [BDEPTH];
    logic signed [DATA_W-1:0] r_act [2][NEURONS];

    logic [WAW-1:0]             w_widx;
    logic [BAW-1:0]             w_bidx;
    logic signed [DATA_W-1:0]   w_x, w_wt, w_bias, w_q, w_hs, w_act;
    logic signed [2*DATA_W-1:0] w_prod;
`ifdef NN_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0]    w_r;
`endif

    // r_pp selects the buffer feeding the current layer; results land in the other one.
    always_comb begin
        w_widx = WAW'(int'(r_layer)*NEURONS*NEURONS + int'(r_neuron)*NEURONS + int'(r_idx));
        w_bidx = BAW'(int'(r_layer)*NEURONS + int'(r_neuron));
        w_x    = r_act[r_pp][r_idx];
        w_wt   = r_w[w_widx];
        w_bias = r_b[w_bidx];
        w_prod = w_x * w_wt;
`ifdef NN_SATURATE_EN
        w_r = r_acc >>> FRAC_BITS;
        if (w_r > SAT_MAX)      w_q = {1'b0, {(DATA_W-1){1'b1}}};
        else if (w_r < SAT_MIN) w_q = {1'b1, {(DATA_W-1){1'b0}}};
        else                    w_q = w_r[DATA_W-1:0];
`else
        w_q = DATA_W'(r_acc >>> FRAC_BITS);
`endif
        w_hs = (w_q >>> 2) + HALF;
        case (r_mode)
            2'd0:    w_act = (w_q < 0) ? '0 : w_q;
            2'd1:    w_act = w_q;
            2'd2:    w_act = (w_hs < 0) ? '0 : ((w_hs > ONE) ? ONE : w_hs);
            default: w_act = (w_q < NEG_ONE) ? NEG_ONE : ((w_q > ONE) ? ONE : w_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WDEPTH; k++) r_w[k] <= '0;
            for (int k = 0; k < BDEPTH; k++) r_b[k] <= '0;
        end else if (cfg_we && r_state == S_IDLE) begin
            if (!cfg_sel && 32'(cfg_addr) < WDEPTH) r_w[cfg_addr[WAW-1:0]] <= cfg_data;
            if (cfg_sel && 32'(cfg_addr) < BDEPTH)  r_b[cfg_addr[BAW-1:0]] <= cfg_data;
        end
    end

    // Handshakes: a word transfers on a rising edge with valid and ready both high; the
    // producer holds valid/data until then, so out_data/out_valid are frozen while out_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mode    <= '0;
            r_pp      <= 1'b0;
            r_layer   <= '0;
            r_neuron  <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < NEURONS; k++) r_act[b][k] <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (in_valid && in_ready) begin
                    r_act[0][0] <= in_data;
                    r_pp        <= 1'b0;
                    r_idx       <= NW'(1);
                    r_mode      <= act_mode;
                    busy        <= 1'b1;
                    r_state     <= S_LOAD;
                end
                S_LOAD: if (in_valid && in_ready) begin
                    r_act[r_pp][r_idx] <= in_data;
                    if (r_idx == N_LAST) begin
                        r_idx    <= '0;
                        r_layer  <= '0;
                        r_neuron <= '0;
                        in_ready <= 1'b0;
                        r_state  <= S_INIT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_INIT: begin
                    r_acc   <= ACC_W'(w_bias) <<< FRAC_BITS;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (r_idx == N_LAST) begin
                        r_idx   <= '0;
                        r_state <= S_ACT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_ACT: begin
                    r_act[~r_pp][r_neuron] <= w_act;
                    if (r_neuron != N_LAST) begin
                        r_neuron <= r_neuron + 1'b1;
                        r_state  <= S_INIT;
                    end else begin
                        r_neuron <= '0;
                        r_pp     <= ~r_pp;
                        if (r_layer == L_LAST) begin
                            r_layer   <= '0;
                            out_valid <= 1'b1;
                            out_data  <= r_act[~r_pp][0];
                            r_state   <= S_OUT;
                        end else begin
                            r_layer <= r_layer + 1'b1;
                            r_state <= S_INIT;
                        end
                    end
                end
                S_OUT: if (out_ready) begin
                    if (r_idx == N_LAST) begin
                        r_idx     <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_idx    <= r_idx + 1'b1;
                        out_data <= r_act[r_pp][r_idx + 1'b1];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
